// File: rtl/bp_pkg.sv
// Shared branch-prediction types: the 2-bit history counter encoding, its reset value,
// and the conditional-branch opcode.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_state_t;

  localparam bp_state_t  BP_INIT = WNT;

  // RV32 conditional branch major opcode
  localparam logic [6:0] B_type  = 7'b1100011;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state function of a 2-bit saturating history counter.
// Taken moves the counter toward ST; not-taken moves it toward SNT.
module bp_sat_counter
  import bp_pkg::*;
(
  input  bp_state_t state,
  input  logic      taken,
  output bp_state_t next_state
);

  // NOTE: default assignment first so every path through this block drives next_state and no latch is inferred.
  always_comb begin
    next_state = state;
    if (taken) begin
      if (state != ST) next_state = bp_state_t'(state + 2'd1);
    end else begin
      if (state != SNT) next_state = bp_state_t'(state - 2'd1);
    end
  end

endmodule

// File: rtl/branch_history_table.sv
// Untagged table of 2-bit branch-history counters. Reads on the ID side are combinational and bypass a same-index EX update.
// EX-side branch outcomes train the table and drive saturating branch and mispredict statistics.
module branch_history_table
  import bp_pkg::*;
#(
  parameter int         ENTRIES    = 16,
  parameter logic [1:0] INIT_STATE = BP_INIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ID_pc,
  input  logic [31:0] EX_pc,
  input  logic [6:0]  EX_op,
  input  logic        EX_actual_taken,
  input  logic        EX_predict_taken,
  output logic        history_reg_1,
  output logic        history_reg_0,
  output logic [31:0] bp_branch_cnt,
  output logic [31:0] bp_miss_cnt
);

  localparam int IW = $clog2(ENTRIES);

  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;
  logic          update;

  bp_state_t     table_q [ENTRIES];
  bp_state_t     table_d [ENTRIES];
  bp_state_t     wr_cur;
  bp_state_t     wr_next;
  bp_state_t     rd_val;

  logic [31:0]   bp_branch_cnt_q, bp_branch_cnt_d;
  logic [31:0]   bp_miss_cnt_q,   bp_miss_cnt_d;

  assign rd_idx = ID_pc[IW+1:2];
  assign wr_idx = EX_pc[IW+1:2];
  assign update = (EX_op == B_type);
  assign wr_cur = table_q[wr_idx];

  // One counter instance serves both the table write and the read bypass.
  bp_sat_counter u_sat_counter (
    .state      (wr_cur),
    .taken      (EX_actual_taken),
    .next_state (wr_next)
  );

  always_comb begin
    rd_val = table_q[rd_idx];
    if (update && (wr_idx == rd_idx)) rd_val = wr_next;
  end

  assign history_reg_1 = rd_val[1];
  assign history_reg_0 = rd_val[0];

  always_comb begin
    table_d         = table_q;
    bp_branch_cnt_d = bp_branch_cnt_q;
    bp_miss_cnt_d   = bp_miss_cnt_q;
    if (update) begin
      table_d[wr_idx] = wr_next;
      if (bp_branch_cnt_q != '1) bp_branch_cnt_d = bp_branch_cnt_q + 32'd1;
      if ((EX_predict_taken != EX_actual_taken) && (bp_miss_cnt_q != '1))
        bp_miss_cnt_d = bp_miss_cnt_q + 32'd1;
    end
  end

  // NOTE: the table is a flop array rather than SRAM, so resetting every entry is both legal and required; no state survives a reset.
  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= bp_state_t'(INIT_STATE);
      bp_branch_cnt_q <= '0;
      bp_miss_cnt_q   <= '0;
    end else begin
      table_q         <= table_d;
      bp_branch_cnt_q <= bp_branch_cnt_d;
      bp_miss_cnt_q   <= bp_miss_cnt_d;
    end
  end

  assign bp_branch_cnt = bp_branch_cnt_q;
  assign bp_miss_cnt   = bp_miss_cnt_q;

  // PC bits outside the index field do not take part in lookup
  logic unused_pc_bits;
  assign unused_pc_bits = ^{ID_pc[31:IW+2], ID_pc[1:0], EX_pc[31:IW+2], EX_pc[1:0]};

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench for branch_history_table: directed scenarios followed by random traffic.
// Every result is compared against a behavioural model of the counter table and statistics.
module tb_branch_history_table;
  import bp_pkg::*;

  localparam int N = 16;

  logic        clk;
  logic        rst;
  logic [31:0] ID_pc;
  logic [31:0] EX_pc;
  logic [6:0]  EX_op;
  logic        EX_actual_taken;
  logic        EX_predict_taken;
  logic        history_reg_1;
  logic        history_reg_0;
  logic [31:0] bp_branch_cnt;
  logic [31:0] bp_miss_cnt;

  branch_history_table #(.ENTRIES(N), .INIT_STATE(2'b01)) dut (
    .clk              (clk),
    .rst              (rst),
    .ID_pc            (ID_pc),
    .EX_pc            (EX_pc),
    .EX_op            (EX_op),
    .EX_actual_taken  (EX_actual_taken),
    .EX_predict_taken (EX_predict_taken),
    .history_reg_1    (history_reg_1),
    .history_reg_0    (history_reg_0),
    .bp_branch_cnt    (bp_branch_cnt),
    .bp_miss_cnt      (bp_miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: counter values as plain integers 0..3, stats as wide integers.
  int      m_tbl [N];
  longint  m_branch;
  longint  m_miss;
  localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic int sat_next(input int v, input logic taken);
    if (taken) return (v >= 3) ? 3 : v + 1;
    return (v <= 0) ? 0 : v - 1;
  endfunction

  function automatic int exp_hist();
    int r = idx_of(ID_pc);
    if (rst && EX_op == B_type && idx_of(EX_pc) == r)
      return sat_next(m_tbl[r], EX_actual_taken);
    return m_tbl[r];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_hist(input string tag);
    check(tag, {30'd0, history_reg_1, history_reg_0}, 32'(exp_hist()));
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_branch"}, bp_branch_cnt, m_branch[31:0]);
    check({tag, "_miss"},   bp_miss_cnt,   m_miss[31:0]);
  endtask

  task automatic set_in(input logic r, input logic [31:0] id, input logic [31:0] ex,
                        input logic [6:0] op, input logic act, input logic pred);
    @(negedge clk);
    rst = r; ID_pc = id; EX_pc = ex; EX_op = op;
    EX_actual_taken = act; EX_predict_taken = pred;
    #1;
  endtask

  // Advance one rising edge and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < N; i++) m_tbl[i] = 1;
      m_branch = 0;
      m_miss   = 0;
    end else if (EX_op == B_type) begin
      m_tbl[idx_of(EX_pc)] = sat_next(m_tbl[idx_of(EX_pc)], EX_actual_taken);
      if (m_branch < SAT) m_branch++;
      if (EX_predict_taken != EX_actual_taken && m_miss < SAT) m_miss++;
    end
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b0, 32'h0, 32'h0, 7'h13, 1'b0, 1'b0);
    tick();
    tick();
    set_in(1'b1, 32'h0, 32'h0, 7'h13, 1'b0, 1'b0);
  endtask

  localparam logic [6:0] NOP = 7'h13;

  initial begin
    logic [31:0] id, ex;
    logic [6:0]  op;

    for (int i = 0; i < N; i++) m_tbl[i] = 0;
    m_branch = 0;
    m_miss   = 0;
    rst = 1'b0; ID_pc = '0; EX_pc = '0; EX_op = NOP;
    EX_actual_taken = 1'b0; EX_predict_taken = 1'b0;

    // Reset state
    do_reset();
    check("rst_hist_0", {30'd0, history_reg_1, history_reg_0}, 32'h1);
    set_in(1'b1, 32'h0000_003C, 32'h0, NOP, 1'b0, 1'b0);
    check("rst_hist_3c", {30'd0, history_reg_1, history_reg_0}, 32'h1);
    check("rst_branch", bp_branch_cnt, 32'h0);
    check("rst_miss", bp_miss_cnt, 32'h0);

    // Train taken three times at 0x10, reading the same PC
    set_in(1'b1, 32'h10, 32'h10, B_type, 1'b1, 1'b0);
    check("taken1", {30'd0, history_reg_1, history_reg_0}, 32'h2);
    tick();
    set_in(1'b1, 32'h10, 32'h10, B_type, 1'b1, 1'b0);
    check("taken2", {30'd0, history_reg_1, history_reg_0}, 32'h3);
    tick();
    set_in(1'b1, 32'h10, 32'h10, B_type, 1'b1, 1'b0);
    check("taken3", {30'd0, history_reg_1, history_reg_0}, 32'h3);
    tick();
    set_in(1'b1, 32'h10, 32'h0, NOP, 1'b0, 1'b0);
    check("taken_stored", {30'd0, history_reg_1, history_reg_0}, 32'h3);
    check("taken_branch", bp_branch_cnt, 32'd3);
    check("taken_miss", bp_miss_cnt, 32'd3);

    // Train not-taken at 0x14 from reset; neighbour entry 4 untouched
    do_reset();
    set_in(1'b1, 32'h14, 32'h14, B_type, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 32'h14, 32'h14, B_type, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 32'h14, 32'h0, NOP, 1'b0, 1'b0);
    check("nt_entry5", {30'd0, history_reg_1, history_reg_0}, 32'h0);
    set_in(1'b1, 32'h10, 32'h0, NOP, 1'b0, 1'b0);
    check("nt_entry4", {30'd0, history_reg_1, history_reg_0}, 32'h1);
    check_stats("nt");

    // Aliasing: 0x04 and 0x44 share entry 1
    do_reset();
    set_in(1'b1, 32'h0, 32'h04, B_type, 1'b1, 1'b1);
    tick();
    set_in(1'b1, 32'h44, 32'h0, NOP, 1'b0, 1'b0);
    check("alias_44", {30'd0, history_reg_1, history_reg_0}, 32'h2);

    // Bypass in the update cycle, then a non-branch that must change nothing
    do_reset();
    set_in(1'b1, 32'h20, 32'h20, B_type, 1'b1, 1'b1);
    check("bypass_h1", {31'd0, history_reg_1}, 32'h1);
    tick();
    set_in(1'b1, 32'h20, 32'h20, 7'h33, 1'b0, 1'b1);
    check("nonbranch_hist", {30'd0, history_reg_1, history_reg_0}, 32'h2);
    tick();
    check("nonbranch_branch", bp_branch_cnt, 32'd1);
    check("nonbranch_miss", bp_miss_cnt, 32'd0);

    // Statistics saturation
    @(negedge clk);
    dut.bp_branch_cnt_q = 32'hFFFF_FFFE;
    m_branch = 64'h0000_0000_FFFF_FFFE;
    set_in(1'b1, 32'h0, 32'h8, B_type, 1'b1, 1'b0);
    tick();
    set_in(1'b1, 32'h0, 32'h8, B_type, 1'b1, 1'b0);
    tick();
    check("sat_branch", bp_branch_cnt, 32'hFFFF_FFFF);
    check_stats("sat");

    // Reset wins over a simultaneous update
    set_in(1'b0, 32'h8, 32'h8, B_type, 1'b1, 1'b0);
    tick();
    set_in(1'b1, 32'h8, 32'h0, NOP, 1'b0, 1'b0);
    check("rstprio_hist", {30'd0, history_reg_1, history_reg_0}, 32'h1);
    check("rstprio_branch", bp_branch_cnt, 32'h0);
    check("rstprio_miss", bp_miss_cnt, 32'h0);
    for (int i = 0; i < N; i++) begin
      set_in(1'b1, 32'(i * 4), 32'h0, NOP, 1'b0, 1'b0);
      check($sformatf("rstprio_e%0d", i), {30'd0, history_reg_1, history_reg_0}, 32'h1);
    end

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      ex = $urandom & 32'h0000_00FF;
      id = ($urandom_range(0, 2) == 0) ? ex : ($urandom & 32'h0000_00FF);
      op = ($urandom_range(0, 2) != 0) ? B_type : 7'($urandom);
      if (op == B_type && n[0]) op = B_type;
      set_in(($urandom_range(0, 39) != 0), id, ex, op, 1'($urandom), 1'($urandom));
      if (rst) check($sformatf("rand_hist_%0d", n), {30'd0, history_reg_1, history_reg_0},
                     32'(exp_hist()));
      tick();
      check_stats($sformatf("rand_%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
